// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit burst memory: one line fill or
// writeback becomes four memory beats, completed by a single resp_o pulse.
module cacheline_adaptor #(
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned BURST_WIDTH = 64,
    parameter int unsigned OFFSET_BITS = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [31:0]            address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [31:0]            address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);
    localparam int unsigned    BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned    CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [31:0]    OFFSET_MASK = 32'((64'd1 << OFFSET_BITS) - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_BURST,
        S_WR_BURST,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [LINE_WIDTH-1:0]  r_line;
    logic [LINE_WIDTH-1:0]  r_line_o;
    logic [BURST_WIDTH-1:0] r_burst;
    logic [31:0]            r_addr;
    logic                   r_read;
    logic                   r_write;
    logic                   r_resp;

    logic [CNT_W-1:0]       w_next_cnt;
    logic                   w_last;
    logic [31:0]            w_addr_aligned;
    logic [LINE_WIDTH-1:0]  w_rd_line;

    assign w_next_cnt     = r_cnt + CNT_W'(1);
    assign w_last         = (r_cnt == LAST_BEAT);
    assign w_addr_aligned = address_i & ~OFFSET_MASK;

    // Line buffer with the current read beat merged into its slot.
    always_comb begin
        w_rd_line = r_line;
        w_rd_line[BURST_WIDTH*r_cnt +: BURST_WIDTH] = burst_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_line   <= '0;
            r_line_o <= '0;
            r_burst  <= '0;
            r_addr   <= '0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_resp   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (write_i) begin
                        r_line  <= line_i;
                        r_addr  <= w_addr_aligned;
                        r_burst <= line_i[BURST_WIDTH-1:0];
                        r_write <= 1'b1;
                        r_state <= S_WR_BURST;
                    end else if (read_i) begin
                        r_addr  <= w_addr_aligned;
                        r_read  <= 1'b1;
                        r_state <= S_RD_BURST;
                    end
                end
                S_RD_BURST: begin
                    if (resp_i) begin
                        r_line <= w_rd_line;
                        r_cnt  <= w_next_cnt;
                        if (w_last) begin
                            r_line_o <= w_rd_line;
                            r_read   <= 1'b0;
                            r_resp   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_WR_BURST: begin
                    if (resp_i) begin
                        r_cnt <= w_next_cnt;
                        if (w_last) begin
                            r_write <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_burst <= r_line[BURST_WIDTH*w_next_cnt +: BURST_WIDTH];
                        end
                    end
                end
                S_DONE: begin
                    r_resp  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign line_o    = r_line_o;
    assign burst_o   = r_burst;
    assign address_o = r_addr;
    assign read_o    = r_read;
    assign write_o   = r_write;
    assign resp_o    = r_resp;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized bench for cacheline_adaptor: a simple memory driver plus a line-level
// reference (expected line, beat order, aligned address, 5+stall latency).
module tb_cacheline_adaptor;
    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [255:0] exp_line_o;

    always #5 clk = ~clk;

    cacheline_adaptor #(
        .LINE_WIDTH (256),
        .BURST_WIDTH(64),
        .OFFSET_BITS(5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .line_i   (line_i),
        .line_o   (line_o),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .resp_o   (resp_o),
        .burst_i  (burst_i),
        .burst_o  (burst_o),
        .address_o(address_o),
        .read_o   (read_o),
        .write_o  (write_o),
        .resp_i   (resp_i)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] junk64();
        return {$urandom, $urandom};
    endfunction

    // Missing completion pulse: force the DUT back to a known state so later
    // transactions are still meaningful.
    task automatic recover();
        rst     = 1'b1;
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'b0;
        @(negedge clk);
        rst        = 1'b0;
        exp_line_o = '0;
    endtask

    task automatic finish_txn(input string tag, input bit hold_extra);
        if (!hold_extra) begin
            read_i  = 1'b0;
            write_i = 1'b0;
        end
        @(negedge clk);
        check({tag, "_resp_pulse"}, resp_o, 1'b0);
        check({tag, "_read_o_idle"}, read_o, 1'b0);
        check({tag, "_write_o_idle"}, write_o, 1'b0);
        read_i  = 1'b0;
        write_i = 1'b0;
        if (hold_extra) begin
            @(negedge clk);
            check({tag, "_hold_no_restart_rd"}, read_o, 1'b0);
            check({tag, "_hold_no_restart_wr"}, write_o, 1'b0);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                           input int stall_pct, input int stall_at, input int stall_n,
                           input bit hold_extra);
        int beats = 0;
        int n_at = 0;
        int n_rand = 0;
        bit stall;
        @(negedge clk);
        read_i    = 1'b1;
        write_i   = 1'b0;
        address_i = addr;
        while (beats < 4) begin
            @(negedge clk);
            check("rd_read_o", read_o, 1'b1);
            check("rd_write_o", write_o, 1'b0);
            check("rd_address_o", address_o, addr & 32'hFFFF_FFE0);
            check("rd_resp_early", resp_o, 1'b0);
            stall = 1'b0;
            if (beats == stall_at && n_at < stall_n) begin
                stall = 1'b1;
                n_at++;
            end else if (n_rand < 10 && $urandom_range(99) < stall_pct) begin
                stall = 1'b1;
                n_rand++;
            end
            if (stall) begin
                resp_i  = 1'b0;
                burst_i = junk64();
            end else begin
                resp_i  = 1'b1;
                burst_i = line[64*beats +: 64];
                beats++;
            end
        end
        @(negedge clk);
        resp_i     = 1'b0;
        burst_i    = junk64();
        exp_line_o = line;
        check("rd_resp_latency", resp_o, 1'b1);
        check("rd_line_o", line_o, exp_line_o);
        check("rd_read_o_drop", read_o, 1'b0);
        if (resp_o !== 1'b1) recover();
        else finish_txn("rd", hold_extra);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input int stall_pct, input bit both, input bit hold_extra);
        int beats = 0;
        int n_rand = 0;
        @(negedge clk);
        write_i   = 1'b1;
        read_i    = both;
        line_i    = line;
        address_i = addr;
        while (beats < 4) begin
            @(negedge clk);
            line_i  = rand_line();
            burst_i = junk64();
            check("wr_write_o", write_o, 1'b1);
            check("wr_read_o", read_o, 1'b0);
            check("wr_address_o", address_o, addr & 32'hFFFF_FFE0);
            check("wr_resp_early", resp_o, 1'b0);
            check("wr_burst_o", burst_o, line[64*beats +: 64]);
            if (n_rand < 10 && $urandom_range(99) < stall_pct) begin
                resp_i = 1'b0;
                n_rand++;
            end else begin
                resp_i = 1'b1;
                beats++;
            end
        end
        @(negedge clk);
        resp_i = 1'b0;
        check("wr_resp_latency", resp_o, 1'b1);
        check("wr_write_o_drop", write_o, 1'b0);
        check("wr_line_o_kept", line_o, exp_line_o);
        if (resp_o !== 1'b1) recover();
        else finish_txn("wr", hold_extra);
    endtask

    task automatic idle_spurious(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            resp_i  = 1'b1;
            burst_i = junk64();
            check("idle_read_o", read_o, 1'b0);
            check("idle_write_o", write_o, 1'b0);
            check("idle_resp_o", resp_o, 1'b0);
            check("idle_line_o", line_o, exp_line_o);
        end
        @(negedge clk);
        resp_i = 1'b0;
        check("idle_line_o_after", line_o, exp_line_o);
    endtask

    logic [255:0] rd_pat;
    logic [255:0] wr_pat;

    initial begin
        rst        = 1'b1;
        line_i     = '0;
        address_i  = '0;
        read_i     = 1'b0;
        write_i    = 1'b0;
        burst_i    = '0;
        resp_i     = 1'b0;
        exp_line_o = '0;
        rd_pat = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        wr_pat = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};

        repeat (3) @(negedge clk);
        check("rst_line_o", line_o, '0);
        check("rst_burst_o", burst_o, '0);
        check("rst_address_o", address_o, '0);
        check("rst_read_o", read_o, 1'b0);
        check("rst_write_o", write_o, 1'b0);
        check("rst_resp_o", resp_o, 1'b0);
        rst = 1'b0;

        do_read(32'h0000_1234, rd_pat, 0, -1, 0, 1'b0);
        check("rd_dir_addr", address_o, 32'h0000_1220);

        // Reset arriving together with the third beat of a read
        @(negedge clk);
        read_i    = 1'b1;
        address_i = 32'h0000_2000;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            resp_i  = 1'b1;
            burst_i = junk64();
            if (b == 2) rst = 1'b1;
        end
        @(negedge clk);
        check("midrst_read_o", read_o, 1'b0);
        check("midrst_resp_o", resp_o, 1'b0);
        check("midrst_line_o", line_o, '0);
        check("midrst_address_o", address_o, '0);
        rst        = 1'b0;
        read_i     = 1'b0;
        resp_i     = 1'b0;
        exp_line_o = '0;
        do_read(32'h0000_1040, rand_line(), 0, -1, 0, 1'b0);

        do_read(32'h0000_1234, rd_pat, 0, 1, 3, 1'b0);

        do_write(32'h8000_00FF, wr_pat, 0, 1'b0, 1'b0);
        check("wr_dir_addr", address_o, 32'h8000_00E0);

        do_write(32'h0000_3000, rand_line(), 20, 1'b1, 1'b0);

        do_write(32'h0000_4444, rand_line(), 0, 1'b0, 1'b0);
        idle_spurious(3);
        do_read(32'h0000_4444, rand_line(), 0, -1, 0, 1'b1);
        idle_spurious(2);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(2))
                0: do_read($urandom, rand_line(), $urandom_range(40), -1, 0, 1'($urandom_range(1)));
                1: do_write($urandom, rand_line(), $urandom_range(40), 1'b0, 1'($urandom_range(1)));
                default: do_write($urandom, rand_line(), $urandom_range(40), 1'b1, 1'b0);
            endcase
            if ($urandom_range(3) == 0) idle_spurious($urandom_range(1, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the cache controller, between the cache's 256-bit line port and a 64-bit burst-oriented physical memory.
- On a cache line fill, it issues one burst read, gathers four 64-bit beats, and returns a full line.
- On a writeback, it latches the line and streams it out as four 64-bit beats.
- Presents a single-response handshake to the cache: `resp_o` pulses for one cycle per completed line transfer.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BURST_WIDTH, 64, memory beat width in bits. BEATS = LINE_WIDTH/BURST_WIDTH = 4.
- OFFSET_BITS, 5, line-offset address bits forced to zero on `address_o`.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- line_i  in  256  line to write back; sampled when a write is accepted.
- line_o  out  256  assembled read line; valid while `resp_o`=1, held afterwards.
- address_i  in  32  cache-side line address.
- read_i  in  1  cache requests a line fill; held until `resp_o`.
- write_i  in  1  cache requests a writeback; held until `resp_o`.
- resp_o  out  1  one-cycle completion pulse.
- burst_i  in  64  memory read beat.
- burst_o  out  64  memory write beat.
- address_o  out  32  memory address: latched `address_i` with bits [4:0] = 0.
- read_o  out  1  memory read request.
- write_o  out  1  memory write request.
- resp_i  in  1  memory beat strobe, one per beat.

Behaviour:
- Reset values (cycle after `rst`=1): state IDLE, beat counter 0, `line_o`=0, `burst_o`=0, `address_o`=0, and `read_o`, `write_o`, `resp_o` all 0. Reset overrides any in-flight transfer; partial data is discarded.
- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If `write_i`=1: latch `line_i` and `address_i`, then go to WR_BURST. Write wins if `read_i` and `write_i` are both high.
  - Else if `read_i`=1: latch `address_i`, then go to RD_BURST.
  - Counter cleared.
- RD_BURST:
  - `read_o`=1 and `address_o` stable.
  - Each cycle with `resp_i`=1: `burst_i` is written into line slice [64*cnt +: 64] and cnt increments. Beat 0 is the lowest-order slice.
  - Cycles without `resp_i` are stalls; the counter holds.
  - On the cycle with the 4th beat (cnt==3 and `resp_i`): go to DONE. `read_o` drops in DONE.
- WR_BURST:
  - `write_o`=1 and `burst_o` = latched line slice [64*cnt +: 64], beat 0 first.
  - On `resp_i`=1: cnt increments and `burst_o` advances next cycle.
  - On the 4th accepted beat: go to DONE. `write_o` drops in DONE.
- DONE:
  - `resp_o`=1 for exactly one cycle.
  - For reads, `line_o` holds the assembled line; it stays unchanged until the next read completes. Writes never modify `line_o`.
  - Next state is IDLE unconditionally. A request still high in IDLE is treated as new, so upstream must drop its request on `resp_o`.
- `resp_i` in IDLE or DONE is ignored.
- `burst_i` is not sampled without `resp_i`.
- Latency, zero memory stall: request seen in IDLE at cycle T; burst phase starts T+1; beats T+1..T+4; `resp_o` at T+5. Minimum 5 cycles per line. Each memory stall cycle adds one.
- Counter is 2 bits and wraps to 0 on entry to DONE.
- `address_o` is held constant for the whole transaction.

Test Plan:
- Reset mid-read: assert `rst` after beat 2 of a read → next cycle `read_o`=0, `resp_o`=0, `line_o`=0. A following read of 0x0000_1040 completes normally.
- Read, no stalls:
  - Stimulus: `read_i`, `address_i`=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive `resp_i` cycles.
  - Required: `address_o`=0x0000_1220; `resp_o` exactly 5 cycles after the request; `line_o`=0x44..44_33..33_22..22_11..11.
- Read with stalls: `resp_i` deasserted for 3 cycles between beats 1 and 2 → `read_o` held high throughout, `resp_o` at cycle 8, same line value.
- Writeback:
  - Stimulus: `write_i`, `line_i`=0xDDDD..._CCCC..._BBBB..._AAAA..., `address_i`=0x8000_00FF; memory asserts `resp_i` 4 cycles.
  - Required: `address_o`=0x8000_00E0; `burst_o` sequence 0xAAAA…, 0xBBBB…, 0xCCCC…, 0xDDDD…; `write_o` drops and `resp_o` pulses once; `line_o` unchanged.
- Simultaneous `read_i` and `write_i` in IDLE → write transaction executes; `read_o` stays 0.
- Back-to-back requests:
  - Stimulus: writeback, then read to the same address held one extra cycle after `resp_o`; spurious `resp_i` pulses injected in IDLE.
  - Required: second transaction starts cleanly with counter 0; spurious pulses do not alter `line_o` or the counter.
